// File: rtl/sdma_chan_arbiter_pkg.sv
// sdma_arb_pkg: shared types and constants for the SDMA channel arbiter.
//   arb_state_e - arbiter FSM states
//   xfer_kind_e - transfer kind latched at grant time (burst or single)
//   MAX_REQ     - largest supported requester count
//   ID_W        - width of a requester index
//   next_id()   - round-robin successor of a requester index
package sdma_arb_pkg;

   localparam int MAX_REQ = 8;
   localparam int ID_W    = 3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_ACTIVE = 3'd2,
      ST_DONE   = 3'd3,
      ST_ERR    = 3'd4
   } arb_state_e;

   typedef enum logic {
      KIND_BURST  = 1'b0,
      KIND_SINGLE = 1'b1
   } xfer_kind_e;

   // Index following id, wrapping from n-1 back to 0.
   function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id, input int n);
      logic [ID_W-1:0] nxt;
      if (int'(id) >= n - 1) begin
         nxt = {ID_W{1'b0}};
      end else begin
         nxt = id + {{(ID_W-1){1'b0}}, 1'b1};
      end
      return nxt;
   endfunction

endpackage

// File: rtl/sdma_chan_arbiter_if.sv
// sdma_chan_arbiter_if: requester-side and cell-macro-side signals of the arbiter.
//   Inputs to arbiter : Enable_i, Req_i, Sreq_i, SDMA_Active_i, SDMA_Done_i, Tmo_Clr_i
//   Outputs of arbiter: Grant_o, Done_o, SDMA_Req_o, SDMA_Sreq_o, Tmo_o, Err_Intr_o,
//                       Busy_o, Cur_Id_o
//   modport master: the arbiter itself; modport slave: the surrounding fabric.
interface sdma_chan_arbiter_if #(parameter int NUM_REQ = 4);
   import sdma_arb_pkg::*;

   logic               Enable_i;
   logic [NUM_REQ-1:0] Req_i;
   logic [NUM_REQ-1:0] Sreq_i;
   logic [NUM_REQ-1:0] Grant_o;
   logic [NUM_REQ-1:0] Done_o;
   logic               SDMA_Req_o;
   logic               SDMA_Sreq_o;
   logic               SDMA_Active_i;
   logic               SDMA_Done_i;
   logic               Tmo_Clr_i;
   logic               Tmo_o;
   logic               Err_Intr_o;
   logic               Busy_o;
   logic [ID_W-1:0]    Cur_Id_o;

   modport master (
      input  Enable_i, Req_i, Sreq_i, SDMA_Active_i, SDMA_Done_i, Tmo_Clr_i,
      output Grant_o, Done_o, SDMA_Req_o, SDMA_Sreq_o, Tmo_o, Err_Intr_o, Busy_o, Cur_Id_o
   );

   modport slave (
      output Enable_i, Req_i, Sreq_i, SDMA_Active_i, SDMA_Done_i, Tmo_Clr_i,
      input  Grant_o, Done_o, SDMA_Req_o, SDMA_Sreq_o, Tmo_o, Err_Intr_o, Busy_o, Cur_Id_o
   );

endinterface

// File: rtl/sdma_chan_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
//   pend    - pending vector, one bit per requester
//   ptr     - highest-priority index for this decision
//   win_gnt - one-hot winner (all zero when nothing pending)
//   win_id  - index of the winner
//   win_any - at least one requester pending
module rr_arbiter
   import sdma_arb_pkg::*;
#(
   parameter int N = 4
)
(
   input  logic [N-1:0]    pend,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    win_gnt,
   output logic [ID_W-1:0] win_id,
   output logic            win_any
);

   logic [2*N-1:0]  dbl_s;
   logic [N-1:0]    rot_s;
   logic [ID_W-1:0] off_s;
   logic [ID_W:0]   sum_s;
   logic [ID_W:0]   wrap_s;

   // Rotating a doubled copy puts the requester at ptr into bit 0.
   assign dbl_s   = {pend, pend} >> ptr;
   assign rot_s   = dbl_s[N-1:0];
   assign win_any = |rot_s;

   // Lowest set offset in the rotated vector; descending scan lets it be written last.
   always_comb begin
      off_s = {ID_W{1'b0}};
      for (int k = N - 1; k >= 0; k--) begin
         if (rot_s[k]) begin
            off_s = ID_W'(k);
         end else begin
            // lower offsets still get their turn later in the scan
         end
      end
   end

   assign sum_s   = {1'b0, ptr} + {1'b0, off_s};
   assign wrap_s  = (sum_s >= (ID_W+1)'(N)) ? (sum_s - (ID_W+1)'(N)) : sum_s;
   assign win_id  = wrap_s[ID_W-1:0];
   assign win_gnt = win_any ? ({{(N-1){1'b0}}, 1'b1} << win_id) : {N{1'b0}};

endmodule

// File: rtl/sdma_chan_arbiter.sv
// sdma_chan_arbiter: shares one SDMA channel among NUM_REQ requesters.
//   WB_CLK - system clock
//   WB_RST - synchronous active-high reset
//   bus    - sdma_chan_arbiter_if.master: requests, grants, completion/error pulses,
//            cell-macro request/active/done handshake, sticky timeout flag.
// A round-robin winner is granted for a whole transfer; its burst/single request is
// driven to the cell macro until the macro reports Active or Done. A transfer that
// sits in REQ/ACTIVE for TMO_CYC cycles is aborted with an error pulse.
module sdma_chan_arbiter
   import sdma_arb_pkg::*;
#(
   parameter int                 NUM_REQ = 4,
   parameter int                 TMO_W   = 16,
   parameter logic [TMO_W-1:0]   TMO_CYC = 16'hFFFF
)
(
   input  logic                WB_CLK,
   input  logic                WB_RST,
   sdma_chan_arbiter_if.master bus
);

   localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
   // Counter holds (cycles spent in REQ/ACTIVE - 1), so this value marks the last allowed cycle.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYC - TMO_ONE;

   arb_state_e         state_r, state_s;
   xfer_kind_e         kind_r, kind_s, win_kind_s;
   logic [ID_W-1:0]    id_r, id_s, ptr_r, win_id_s;
   logic [NUM_REQ-1:0] pend_s, win_gnt_s, grant_r, done_r;
   logic [TMO_W-1:0]   cnt_r;
   logic               win_any_s, launch_s, tmo_hit_s, in_xfer_s;
   logic               sdma_req_r, sdma_sreq_r, tmo_r, err_r, busy_r;

   assign pend_s     = bus.Req_i | bus.Sreq_i;
   // Burst wins when the winner raises both request kinds.
   assign win_kind_s = (|(bus.Req_i & win_gnt_s)) ? KIND_BURST : KIND_SINGLE;
   assign tmo_hit_s  = (cnt_r == TMO_LAST);

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .pend    (pend_s),
      .ptr     (ptr_r),
      .win_gnt (win_gnt_s),
      .win_id  (win_id_s),
      .win_any (win_any_s)
   );

   // Next-state decode; Done beats timeout expiry, expiry beats Active.
   always_comb begin
      state_s  = state_r;
      launch_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.Enable_i && win_any_s) begin
               state_s  = ST_REQ;
               launch_s = 1'b1;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (bus.SDMA_Done_i) begin
               state_s = ST_DONE;
            end else if (tmo_hit_s) begin
               state_s = ST_ERR;
            end else if (bus.SDMA_Active_i) begin
               state_s = ST_ACTIVE;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_ACTIVE: begin
            if (bus.SDMA_Done_i) begin
               state_s = ST_DONE;
            end else if (tmo_hit_s) begin
               state_s = ST_ERR;
            end else begin
               state_s = ST_ACTIVE;
            end
         end
         ST_DONE: state_s = ST_IDLE;
         ST_ERR:  state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
      kind_s    = launch_s ? win_kind_s : kind_r;
      id_s      = launch_s ? win_id_s : id_r;
      in_xfer_s = (state_s == ST_REQ) || (state_s == ST_ACTIVE);
   end

   // State, bookkeeping and registered outputs, all decoded from the next state.
   always_ff @(posedge WB_CLK) begin
      if (WB_RST) begin
         state_r     <= ST_IDLE;
         kind_r      <= KIND_BURST;
         id_r        <= {ID_W{1'b0}};
         ptr_r       <= {ID_W{1'b0}};
         cnt_r       <= {TMO_W{1'b0}};
         grant_r     <= {NUM_REQ{1'b0}};
         done_r      <= {NUM_REQ{1'b0}};
         sdma_req_r  <= 1'b0;
         sdma_sreq_r <= 1'b0;
         tmo_r       <= 1'b0;
         err_r       <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         kind_r      <= kind_s;
         id_r        <= id_s;
         ptr_r       <= ((state_s == ST_DONE) || (state_s == ST_ERR)) ? next_id(id_r, NUM_REQ) : ptr_r;
         cnt_r       <= launch_s ? {TMO_W{1'b0}} :
                        (((state_r == ST_REQ) || (state_r == ST_ACTIVE)) ? (cnt_r + TMO_ONE) : cnt_r);
         grant_r     <= in_xfer_s ? (launch_s ? win_gnt_s : grant_r) : {NUM_REQ{1'b0}};
         done_r      <= (state_s == ST_DONE) ? grant_r : {NUM_REQ{1'b0}};
         sdma_req_r  <= (state_s == ST_REQ) && (kind_s == KIND_BURST);
         sdma_sreq_r <= (state_s == ST_REQ) && (kind_s == KIND_SINGLE);
         // A new timeout outranks a clear arriving in the same cycle.
         tmo_r       <= (state_s == ST_ERR) ? 1'b1 : (bus.Tmo_Clr_i ? 1'b0 : tmo_r);
         err_r       <= (state_s == ST_ERR);
         busy_r      <= (state_s != ST_IDLE);
      end
   end

   assign bus.Grant_o     = grant_r;
   assign bus.Done_o      = done_r;
   assign bus.SDMA_Req_o  = sdma_req_r;
   assign bus.SDMA_Sreq_o = sdma_sreq_r;
   assign bus.Tmo_o       = tmo_r;
   assign bus.Err_Intr_o  = err_r;
   assign bus.Busy_o      = busy_r;
   assign bus.Cur_Id_o    = id_r;

endmodule
